// File: rtl/keccak_host_sequencer.sv
// Host-side sequencer for a masked Keccak core: loads LANES share-concatenated
// lanes into the core, releases it to permute, waits for Ready under a cycle
// watchdog, then unloads OUT_LANES rate lanes to the host.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-low reset
//   StartxSI             start request, honoured in IDLE only
//   DataInxDI/ValidxSI/ReadyxSO    host -> core lane stream
//   CoreResetxSO         active-high hold of the core (low lets it run)
//   CoreShiftxSO         one-lane shift of the core state
//   CoreDataxDO          lane shifted into the core during load
//   CoreLanexDI          core lane 0, read during unload
//   CoreReadyxSI         core permutation finished
//   DataOutxDO/ValidxSO/ReadyxSI   core -> host lane stream
//   BusyxSO, DonexSO, ErrorxSO     status (Done is a one-cycle pulse, Error sticky)
module keccak_host_sequencer #(
   parameter int unsigned W         = 8,
   parameter int unsigned SHARES    = 2,
   parameter int unsigned LANES     = 25,
   parameter int unsigned OUT_LANES = 4,
   parameter int unsigned TIMEOUT   = 31
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  StartxSI,
   input  logic [SHARES*W-1:0]   DataInxDI,
   input  logic                  DataInValidxSI,
   output logic                  DataInReadyxSO,
   output logic                  CoreResetxSO,
   output logic                  CoreShiftxSO,
   output logic [SHARES*W-1:0]   CoreDataxDO,
   input  logic [SHARES*W-1:0]   CoreLanexDI,
   input  logic                  CoreReadyxSI,
   output logic [SHARES*W-1:0]   DataOutxDO,
   output logic                  DataOutValidxSO,
   input  logic                  DataOutReadyxSI,
   output logic                  BusyxSO,
   output logic                  DonexSO,
   output logic                  ErrorxSO
);

   localparam int unsigned DW = SHARES * W;
   localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] LAST_IN  = CW'(LANES - 1);
   localparam logic [CW-1:0] LAST_OUT = CW'(OUT_LANES - 1);
   localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_UNLOAD,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   lane_q, lane_d;
   logic [TW-1:0]   wd_q, wd_d;
   logic            err_q, err_d;

   // State and counter registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      wd_d    = wd_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (StartxSI) begin
               state_d = S_LOAD;
               lane_d  = '0;
               wd_d    = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (DataInValidxSI) begin
               if (lane_q == LAST_IN) begin
                  state_d = S_RUN;
                  lane_d  = '0;
                  wd_d    = '0;
               end else begin
                  lane_d = lane_q + CW'(1);
               end
            end
         end
         S_RUN: begin
            // Ready takes priority over an expiring watchdog in the same cycle
            if (CoreReadyxSI) begin
               state_d = S_UNLOAD;
               lane_d  = '0;
            end else if (wd_q == WD_MAX) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + TW'(1);
            end
         end
         S_UNLOAD: begin
            if (DataOutReadyxSI) begin
               if (lane_q == LAST_OUT) begin
                  state_d = S_DONE;
                  lane_d  = '0;
               end else begin
                  lane_d = lane_q + CW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore outputs plus the handshake-qualified shift/data paths
   always_comb begin
      CoreResetxSO    = 1'b1;
      DataInReadyxSO  = 1'b0;
      CoreShiftxSO    = 1'b0;
      CoreDataxDO     = '0;
      DataOutxDO      = '0;
      DataOutValidxSO = 1'b0;
      BusyxSO         = (state_q != S_IDLE);
      DonexSO         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
         end
         S_LOAD: begin
            DataInReadyxSO = 1'b1;
            CoreDataxDO    = DataInxDI;
            CoreShiftxSO   = DataInValidxSI;
         end
         S_RUN: begin
            CoreResetxSO = 1'b0;
         end
         S_UNLOAD: begin
            // Core is kept released so it holds its finished state while shifting out
            CoreResetxSO    = 1'b0;
            DataOutValidxSO = 1'b1;
            DataOutxDO      = CoreLanexDI;
            CoreShiftxSO    = DataOutReadyxSI;
         end
         S_DONE: begin
            DonexSO = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign ErrorxSO = err_q;

   logic [DW-1:0] unused_dw;
   assign unused_dw = '0;

endmodule

// File: tb/tb_keccak_host_sequencer.sv
// Self-checking bench for keccak_host_sequencer with a behavioural core model.
module tb_keccak_host_sequencer;

   localparam int W         = 8;
   localparam int SHARES    = 2;
   localparam int LANES     = 25;
   localparam int OUT_LANES = 4;
   localparam int TIMEOUT   = 31;
   localparam int SW        = SHARES * W;
   localparam int BUDGET    = 2000;
   localparam logic [SW-1:0] PMASK = 16'h5AC3;

   logic          Clock;
   logic          Reset;
   logic          StartxSI;
   logic [SW-1:0] DataInxDI;
   logic          DataInValidxSI;
   logic          DataInReadyxSO;
   logic          CoreResetxSO;
   logic          CoreShiftxSO;
   logic [SW-1:0] CoreDataxDO;
   logic [SW-1:0] CoreLanexDI;
   logic          CoreReadyxSI;
   logic [SW-1:0] DataOutxDO;
   logic          DataOutValidxSO;
   logic          DataOutReadyxSI;
   logic          BusyxSO;
   logic          DonexSO;
   logic          ErrorxSO;

   int vectors;
   int miscompares;

   keccak_host_sequencer dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .StartxSI        (StartxSI),
      .DataInxDI       (DataInxDI),
      .DataInValidxSI  (DataInValidxSI),
      .DataInReadyxSO  (DataInReadyxSO),
      .CoreResetxSO    (CoreResetxSO),
      .CoreShiftxSO    (CoreShiftxSO),
      .CoreDataxDO     (CoreDataxDO),
      .CoreLanexDI     (CoreLanexDI),
      .CoreReadyxSI    (CoreReadyxSI),
      .DataOutxDO      (DataOutxDO),
      .DataOutValidxSO (DataOutValidxSO),
      .DataOutReadyxSI (DataOutReadyxSI),
      .BusyxSO         (BusyxSO),
      .DonexSO         (DonexSO),
      .ErrorxSO        (ErrorxSO)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Core model: a lane shift register; the permutation rotates lanes by one
   // and XORs a mask, and Ready rises in the ready_after-th released cycle.
   int            ready_after;   // 0 = never ready
   int            run_cnt;
   bit            permuted;
   logic [SW-1:0] core_lanes [LANES];

   assign CoreLanexDI  = core_lanes[0];
   assign CoreReadyxSI = (ready_after != 0) && !CoreResetxSO && (run_cnt + 1 >= ready_after);

   always @(posedge Clock) begin
      if (CoreResetxSO) begin
         run_cnt  <= 0;
         permuted <= 1'b0;
      end else if (run_cnt < 10000) begin
         run_cnt <= run_cnt + 1;
      end
      if (CoreShiftxSO) begin
         for (int i = 0; i < LANES - 1; i++) core_lanes[i] <= core_lanes[i+1];
         core_lanes[LANES-1] <= CoreDataxDO;
      end else if (CoreReadyxSI && !permuted) begin
         for (int i = 0; i < LANES; i++) core_lanes[i] <= core_lanes[(i+1) % LANES] ^ PMASK;
         permuted <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      StartxSI        = 1'b0;
      DataInxDI       = '0;
      DataInValidxSI  = 1'b0;
      DataOutReadyxSI = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".core_reset"}, 32'(CoreResetxSO), 32'd1);
      check({tag, ".in_ready"},   32'(DataInReadyxSO), 32'd0);
      check({tag, ".shift"},      32'(CoreShiftxSO), 32'd0);
      check({tag, ".out_valid"},  32'(DataOutValidxSO), 32'd0);
      check({tag, ".busy"},       32'(BusyxSO), 32'd0);
      check({tag, ".done"},       32'(DonexSO), 32'd0);
      check({tag, ".error"},      32'(ErrorxSO), 32'd0);
   endtask

   // One accepted Start through to Done / watchdog error / planted reset.
   // Entered and left just after a rising edge.
   task automatic do_op(input string tag, input int rdy_after, input int vin_pct,
                        input int rdy_pct, input bit directed, input bit start_noise,
                        input int abort_load, input int abort_unload, input bit expect_err);
      logic [SW-1:0] lanes_in [LANES];
      logic [SW-1:0] sent [$];
      logic [SW-1:0] prev_out;
      logic [SW-1:0] exp_out;
      logic [7:0]    b;
      int  next_in, n_load_sh, n_unload_sh, n_run, n_done, n_out;
      bit  prev_bp, in_unload, aborting, finished;

      for (int k = 0; k < LANES; k++) begin
         b = 8'(k);
         lanes_in[k] = directed ? {~b, b} : SW'($urandom);
      end
      next_in = 0; n_load_sh = 0; n_unload_sh = 0; n_run = 0; n_done = 0; n_out = 0;
      prev_bp = 1'b0; in_unload = 1'b0; aborting = 1'b0; finished = 1'b0;
      prev_out = '0;
      ready_after = rdy_after;

      idle_inputs();
      StartxSI = 1'b1;
      @(negedge Clock);
      @(posedge Clock); #1;

      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         StartxSI        = start_noise && ($urandom_range(1) == 1);
         DataInxDI       = lanes_in[(next_in < LANES) ? next_in : LANES - 1];
         DataInValidxSI  = ($urandom_range(99) < vin_pct);
         DataOutReadyxSI = ($urandom_range(99) < rdy_pct);
         if (abort_load >= 0 && next_in == abort_load) begin
            DataInValidxSI = 1'b1;
            Reset = 1'b0;
            aborting = 1'b1;
         end
         if (abort_unload >= 0 && in_unload && n_out == abort_unload) begin
            Reset = 1'b0;
            aborting = 1'b1;
         end
         @(negedge Clock);
         if (aborting) begin
            @(posedge Clock); #1;
            Reset = 1'b1;
            idle_inputs();
            @(negedge Clock);
            check_reset_outputs({tag, ".after_reset"});
            @(posedge Clock); #1;
            @(negedge Clock);
            check({tag, ".no_done_after_reset"}, 32'(DonexSO), 32'd0);
            check({tag, ".idle_after_reset"}, 32'(BusyxSO), 32'd0);
            @(posedge Clock); #1;
            return;
         end
         if (cyc == 0) begin
            check({tag, ".first_in_ready"}, 32'(DataInReadyxSO), 32'd1);
            check({tag, ".error_cleared"}, 32'(ErrorxSO), 32'd0);
         end
         if (CoreShiftxSO && CoreResetxSO) begin
            n_load_sh++;
            check({tag, ".core_data"}, 32'(CoreDataxDO), 32'(DataInxDI));
         end
         if (DataInValidxSI && DataInReadyxSO) begin
            sent.push_back(DataInxDI);
            next_in++;
         end
         if (!CoreResetxSO && !DataOutValidxSO) n_run++;
         if (DataOutValidxSO) begin
            in_unload = 1'b1;
            if (prev_bp) check({tag, ".out_stable"}, 32'(DataOutxDO), 32'(prev_out));
         end
         if (DataOutValidxSO && DataOutReadyxSI) begin
            if (sent.size() == LANES) begin
               exp_out = sent[(n_out + 1) % LANES] ^ PMASK;
               check($sformatf("%s.out%0d", tag, n_out), 32'(DataOutxDO), 32'(exp_out));
            end else begin
               check({tag, ".lanes_before_unload"}, 32'(sent.size()), 32'(LANES));
            end
            n_out++;
         end
         if (CoreShiftxSO && !CoreResetxSO) n_unload_sh++;
         prev_bp  = DataOutValidxSO && !DataOutReadyxSI;
         prev_out = DataOutxDO;
         if (DonexSO) begin
            n_done++;
            finished = 1'b1;
            break;
         end
         if (!BusyxSO && sent.size() == LANES) begin
            finished = 1'b1;
            break;
         end
         @(posedge Clock); #1;
      end

      if (!finished) begin
         check({tag, ".cycle_budget"}, 32'd0, 32'd1);
         idle_inputs();
         @(posedge Clock); #1;
         return;
      end

      check({tag, ".load_shifts"}, 32'(n_load_sh), 32'(LANES));
      if (expect_err) begin
         check({tag, ".run_cycles"}, 32'(n_run), 32'(TIMEOUT + 1));
         check({tag, ".error_set"}, 32'(ErrorxSO), 32'd1);
         check({tag, ".core_held"}, 32'(CoreResetxSO), 32'd1);
         check({tag, ".no_unload"}, 32'(n_unload_sh), 32'd0);
         check({tag, ".no_done"}, 32'(n_done), 32'd0);
         idle_inputs();
         @(posedge Clock); #1;
      end else begin
         check({tag, ".run_cycles"}, 32'(n_run), 32'(rdy_after));
         check({tag, ".unload_shifts"}, 32'(n_unload_sh), 32'(OUT_LANES));
         check({tag, ".out_lanes"}, 32'(n_out), 32'(OUT_LANES));
         check({tag, ".done_count"}, 32'(n_done), 32'd1);
         check({tag, ".no_error"}, 32'(ErrorxSO), 32'd0);
         @(posedge Clock); #1;
         idle_inputs();
         @(negedge Clock);
         check({tag, ".done_one_cycle"}, 32'(DonexSO), 32'd0);
         check({tag, ".busy_low_after"}, 32'(BusyxSO), 32'd0);
         check({tag, ".core_held_after"}, 32'(CoreResetxSO), 32'd1);
         @(posedge Clock); #1;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      ready_after = 0;
      Reset       = 1'b0;
      idle_inputs();
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check_reset_outputs("reset");
      @(posedge Clock); #1;
      Reset = 1'b1;
      @(negedge Clock);
      check("idle_busy", 32'(BusyxSO), 32'd0);
      check("idle_core_reset", 32'(CoreResetxSO), 32'd1);
      @(posedge Clock); #1;

      // Back-to-back directed lanes, Ready after 13 released cycles
      do_op("directed", 13, 100, 100, 1'b1, 1'b0, -1, -1, 1'b0);

      // Random valid and ready gaps
      do_op("gaps_a", 1 + int'($urandom_range(19)), 50, 50, 1'b0, 1'b0, -1, -1, 1'b0);
      do_op("gaps_b", 1 + int'($urandom_range(19)), 50, 50, 1'b0, 1'b0, -1, -1, 1'b0);

      // Core never ready: watchdog error, then the next Start clears it
      do_op("timeout", 0, 100, 100, 1'b0, 1'b0, -1, -1, 1'b1);
      check("error_sticky_idle", 32'(ErrorxSO), 32'd1);
      do_op("after_timeout", 5, 70, 70, 1'b0, 1'b0, -1, -1, 1'b0);

      // Ready coincides with the final watchdog cycle
      do_op("ready_at_limit", TIMEOUT + 1, 100, 100, 1'b0, 1'b0, -1, -1, 1'b0);

      // Reset planted on the 10th load lane and mid-unload, each followed by a clean op
      do_op("abort_load", 10, 100, 100, 1'b0, 1'b0, 9, -1, 1'b0);
      do_op("fresh_a", 10, 100, 100, 1'b0, 1'b0, -1, -1, 1'b0);
      do_op("abort_unload", 7, 100, 50, 1'b0, 1'b0, -1, 2, 1'b0);
      do_op("fresh_b", 7, 60, 60, 1'b0, 1'b0, -1, -1, 1'b0);

      // Start pulses while busy are ignored
      do_op("start_noise_a", 9, 60, 60, 1'b0, 1'b1, -1, -1, 1'b0);
      do_op("start_noise_b", 1 + int'($urandom_range(25)), 50, 50, 1'b0, 1'b1, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
